// File: rtl/djb2_pkg.sv
// Shared constants for the DJB2 streaming hash engine: default seed, byte width and FSM encodings.
package djb2_pkg;

  localparam int unsigned DJB2_SEED_DEFAULT = 5381;
  localparam int unsigned BYTE_W            = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/djb2_step.sv
// Single combinational DJB2 step: acc*33 combined with one byte.
// Define DJB2_XOR_MODE_EN for the djb2a (xor) variant; default is the additive form.
module djb2_step
  import djb2_pkg::*;
#(
  parameter int unsigned HASH_W = 64
) (
  input  logic [HASH_W-1:0] acc,
  input  logic [BYTE_W-1:0] data,
  output logic [HASH_W-1:0] acc_next
);

  logic [HASH_W-1:0] mul33;
  logic [HASH_W-1:0] data_ext;

  // Shift-and-add is acc*33; truncation to HASH_W gives the mod 2^HASH_W wrap.
  assign mul33    = (acc << 5) + acc;
  assign data_ext = {{(HASH_W-BYTE_W){1'b0}}, data};

`ifdef DJB2_XOR_MODE_EN
  assign acc_next = mul33 ^ data_ext;
`else
  assign acc_next = mul33 + data_ext;
`endif

endmodule

// File: rtl/djb2_stream_hasher.sv
// Streaming DJB2 hasher: one byte per cycle in, one framed-message hash out over valid/ready.
// Build option DJB2_XOR_MODE_EN selects the djb2a step inside djb2_step.
module djb2_stream_hasher
  import djb2_pkg::*;
#(
  parameter int unsigned HASH_W  = 64,
  parameter logic [63:0] SEED    = 64'(DJB2_SEED_DEFAULT),
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [HASH_W-1:0] hash_out,
  output logic [CNT_W-1:0]  byte_count,
  output logic              overflow
);

  localparam logic [HASH_W-1:0] SEED_T = SEED[HASH_W-1:0];

  logic [1:0]        state_q, state_d;
  logic [HASH_W-1:0] acc_q, acc_d;
  logic [HASH_W-1:0] hash_d;
  logic              valid_d;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_d;
  logic [HASH_W-1:0] step;
  logic              accept;
  logic              saturated;

  djb2_step #(
    .HASH_W (HASH_W)
  ) u_step (
    .acc      (acc_q),
    .data     (in_data),
    .acc_next (step)
  );

  // State-decoded only; Reset gating keeps in_ready low for the whole reset pulse.
  assign in_ready  = ~Reset & (state_q != HOLD);
  assign accept    = in_valid & in_ready;
  assign saturated = (byte_count == CNT_W'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hash_d  = hash_out;
    valid_d = hash_valid;
    count_d = byte_count;
    ovf_d   = overflow;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          // Bytes past MAX_LEN are consumed but not hashed; in_last still closes the frame.
          if (saturated) begin
            ovf_d = 1'b1;
          end else begin
            acc_d   = step;
            count_d = byte_count + CNT_W'(1);
          end
          if (in_last) begin
            state_d = HOLD;
            hash_d  = saturated ? acc_q : step;
            valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (hash_valid && hash_ready) begin
          state_d = IDLE;
          acc_d   = SEED_T;
          count_d = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      acc_q      <= SEED_T;
      hash_out   <= '0;
      hash_valid <= 1'b0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      hash_out   <= hash_d;
      hash_valid <= valid_d;
      byte_count <= count_d;
      overflow   <= ovf_d;
    end
  end

endmodule

// File: doc/djb2_stream_hasher.md
# djb2_stream_hasher

Streaming DJB2 hash engine that accepts one message byte per cycle over a valid/ready handshake and returns the hash of each framed message over a second valid/ready handshake. It generalises the fixed-word hashing used in the string-hash transmission path. Hash width, seed and maximum message length are parametrised, and any byte source can feed it, including word ROMs, a UART receiver or a FIFO. It sits between the byte producer and the transmit/compare logic that consumes finished hashes.

## Interface
- HASH_W, 64, accumulator and result width; legal range 16..64
- SEED, 5381, initial accumulator value, truncated to HASH_W
- MAX_LEN, 16, maximum bytes hashed per message; legal range ≥ 2
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- in_valid  input  1  byte offered
- in_ready  output  1  engine can accept a byte this cycle
- in_data  input  8  message byte
- in_last  input  1  qualifies the final byte of the message; sampled with in_valid
- hash_valid  output  1  result available
- hash_ready  input  1  consumer accepts result
- hash_out  output  HASH_W  final hash; stable while hash_valid=1
- byte_count  output  $clog2(MAX_LEN+1)  bytes hashed in the current or held message
- overflow  output  1  message exceeded MAX_LEN; bytes beyond the limit were dropped

## Operation
- FSM states are IDLE, ACCUM and HOLD.
- Reset values: state=IDLE, acc=SEED, hash_out=0, hash_valid=0, in_ready=0 while Reset is asserted, byte_count=0, overflow=0.
- in_ready=1 in IDLE and ACCUM. in_ready=0 in HOLD.
- Accepted byte means in_valid & in_ready.
- Step function: acc_next = ((acc<<5) + acc + in_data) mod 2^HASH_W. in_data is zero-extended before the add.
- IDLE → ACCUM on an accepted byte with in_last=0. The byte is hashed and byte_count becomes 1.
- IDLE or ACCUM → HOLD on an accepted byte with in_last=1. The byte is hashed unless the count is saturated. hash_out is loaded with the final acc and hash_valid=1.
- A single-byte message is a byte with in_last=1 accepted in IDLE. Zero-length messages do not exist.
- Saturation: if byte_count==MAX_LEN and another byte is accepted, that byte is not hashed. byte_count holds at MAX_LEN and overflow is set. The byte is still consumed, and in_last on it is still honoured.
- HOLD → IDLE when hash_valid & hash_ready. On that transition acc=SEED, byte_count=0, overflow=0, hash_valid=0.
- hash_out retains its last value after the handshake until the next result is loaded.
- Reset asserted mid-message or in HOLD aborts immediately. The partial or held result is discarded and never presented.

## Timing
- Throughput: 1 byte per cycle in IDLE/ACCUM.
- Latency: hash_valid rises on the clock edge that accepts the in_last byte, so it is visible the next cycle.
- Result accepted on edge k → in_ready=1 from cycle k+1. There is no same-cycle bypass, so a message of N bytes occupies at least N+1 cycles.
- in_ready and hash_valid are registered or state-decoded only. They have no combinational path from in_valid or hash_ready.
- hash_ready held low keeps the engine in HOLD indefinitely, and in_ready stays 0.

## Configuration
- DJB2_XOR_MODE_EN defined: the step uses the djb2a variant, acc_next = ((acc<<5) + acc) ^ in_data.
- DJB2_XOR_MODE_EN undefined: the additive step above applies.
- All handshake, saturation and timing behaviour is identical in both builds.

## Structure
- djb2_pkg holds DJB2_SEED_DEFAULT=5381, the state enum (IDLE, ACCUM, HOLD) and the byte-width constant 8.
- Sub-module djb2_step is a combinational single-step function parametrised by HASH_W. It contains the DJB2_XOR_MODE_EN selection. The top level holds the FSM, accumulator, counter and output registers.

## Test plan
- Hash "a" (0x61, in_last=1), HASH_W=64, additive build → hash_out=0x2B606 (177670), byte_count=1, overflow=0. The result is valid the cycle after acceptance.
- Hash "ab", back-to-back → hash_out=0x597728 (5863208), byte_count=2. in_ready stays 1 until in_last is accepted.
- HASH_W=16, hash "a" → hash_out=0xB606 (wrap-around truncation). With DJB2_XOR_MODE_EN and HASH_W=64, hash "a" → hash_out=0x2B5C4.
- hash_ready held 0 for 10 cycles in HOLD → hash_out stable and in_ready=0 throughout. Then raising hash_ready for 1 cycle → hash_valid=0 next cycle and a following "a" hashes to 0x2B606 again, proving the seed reload.
- MAX_LEN=4 with 6 bytes "abcdef" → the result equals the hash of "abcd", byte_count=4 and overflow=1. Both clear after the result handshake.
- Reset pulsed after 2 bytes of "abc" → in_ready=0 and all outputs at reset values while Reset=1. After release, "a" → 0x2B606 and no stale result appears.
